// File: rtl/mem_access_ctrl.sv
// Initiator-side controller for a single-port synchronous RAM: single-beat writes
// and 1-4 beat incrementing read bursts, returned over a valid/ready response channel.
module mem_access_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [1:0]        req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_last,
  output logic              busy,
  output logic              mem_write,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ISSUE,
    RD_CAPTURE,
    WR_ISSUE,
    RESP
  } state_t;

  state_t     state;
  logic [1:0] beats_left;

  // Gated by rst_n so nothing can be accepted while reset is asserted.
  assign req_ready = (state == IDLE) && rst_n;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      beats_left  <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      mem_address <= '0;
      mem_data_in <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_address <= req_addr;
            if (req_write) begin
              mem_data_in <= req_wdata;
              beats_left  <= '0;
              mem_write   <= 1'b1;
              state       <= WR_ISSUE;
            end else begin
              beats_left <= req_len;
              mem_read   <= 1'b1;
              state      <= RD_ISSUE;
            end
          end
        end
        WR_ISSUE: begin
          mem_write <= 1'b0;
          rsp_data  <= mem_data_in;
          rsp_last  <= 1'b1;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RD_ISSUE: begin
          mem_read <= 1'b0;
          state    <= RD_CAPTURE;
        end
        RD_CAPTURE: begin
          // RAM output is valid now, one cycle after the read strobe was sampled.
          rsp_data  <= mem_data_out;
          rsp_last  <= (beats_left == 2'd0);
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              mem_address <= mem_address + 1'b1;
              beats_left  <= beats_left - 1'b1;
              mem_read    <= 1'b1;
              state       <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
